bch_chien_search_serial: RTL and testbench

//  Chien search stage, directly downstream of the serial BMA key solver. Accepts sigma(x) and err_count

---
 rtl/bch_chien_search_serial_pkg.sv | 64 ++++++
 rtl/bch_chien_search_serial_term.sv | 56 +++++
 rtl/bch_chien_search_serial.sv | 132 +++++++++++++
 tb/tb_bch_chien_search_serial.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_chien_search_serial_pkg.sv
// ---------------------------------------------------------------------------
// bch_chien_search_serial_pkg
//   Shared constants and elaboration-time GF(2^M) helpers for the serial
//   Chien search. Everything here is evaluated as constants while the design
//   is elaborated, so no arithmetic is synthesised from this file.
//   Contents:
//     BCH_M/BCH_T/BCH_L  default code geometry (BCH(15,7): M=4, T=2, L=15)
//     chien_state_t      FSM state encoding
//     prim_poly()        primitive polynomial for GF(2^m), bit m included
//     alpha_pow()        alpha^e as an integer bit pattern (e may be negative)
//     sigma_sz()/err_sz() port widths derived from M and T
// ---------------------------------------------------------------------------
package bch_chien_search_serial_pkg;

  localparam int BCH_M = 4;
  localparam int BCH_T = 2;
  localparam int BCH_L = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chien_state_t;

  function automatic int prim_poly(input int m);
    case (m)
      3:       return 11;
      4:       return 19;
      5:       return 37;
      6:       return 67;
      7:       return 137;
      8:       return 285;
      9:       return 529;
      10:      return 1033;
      11:      return 2053;
      12:      return 4179;
      default: return 19;
    endcase
  endfunction

  // Repeated multiply-by-x with reduction; exponent is folded into 0..2^m-2.
  function automatic int alpha_pow(input int e, input int m);
    int n;
    int ee;
    int v;
    n  = (1 << m) - 1;
    ee = e % n;
    if (ee < 0) ee = ee + n;
    v = 1;
    for (int k = 0; k < ee; k++) begin
      v = v << 1;
      if ((v & (1 << m)) != 0) v = v ^ prim_poly(m);
    end
    return v;
  endfunction

  function automatic int sigma_sz(input int m, input int t);
    return (t + 1) * m;
  endfunction

  function automatic int err_sz(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bch_chien_search_serial_term.sv
// ---------------------------------------------------------------------------
// bch_chien_search_serial_term  (chien term cell)
//   One locator term register r_i. On load it captures coeff * alpha^LOAD_POWER,
//   on step it multiplies itself by alpha^POWER. Both multipliers are by
//   constants, so they reduce to small XOR networks. With POWER = LOAD_POWER = 0
//   the cell is a plain hold register (term 0).
//   Ports:
//     clk, reset  clock, synchronous active-high reset (clears the term)
//     load        capture scaled coeff (has priority over step)
//     step        advance by one codeword position
//     coeff       sigma_i, M bits
//     term        current r_i
// ---------------------------------------------------------------------------
module bch_chien_search_serial_term
  import bch_chien_search_serial_pkg::*;
#(
  parameter int M          = 4,
  parameter int POWER      = 0,
  parameter int LOAD_POWER = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [M-1:0] coeff,
  output logic [M-1:0] term
);

  localparam logic [M-1:0] POLY_LO = M'(prim_poly(M));
  localparam logic [M-1:0] STEP_C  = M'(alpha_pow(POWER, M));
  localparam logic [M-1:0] LOAD_C  = M'(alpha_pow(LOAD_POWER, M));

  // Shift-and-add GF(2^M) product; with c constant this folds to XOR gates.
  function automatic logic [M-1:0] mul_const(input logic [M-1:0] a, input logic [M-1:0] c);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (c[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY_LO : '0);
    end
    return acc;
  endfunction

  logic [M-1:0] term_reg;

  always_ff @(posedge clk) begin
    if (reset)     term_reg <= '0;
    else if (load) term_reg <= mul_const(coeff, LOAD_C);
    else if (step) term_reg <= mul_const(term_reg, STEP_C);
  end

  assign term = term_reg;

endmodule

// File: rtl/bch_chien_search_serial.sv
// ---------------------------------------------------------------------------
// bch_chien_search_serial
//   Serial Chien search: takes sigma(x)/err_count from the key solver and
//   emits one error flag per codeword position (position 0 first). Position j
//   evaluates sigma(alpha^(j-L+1)); a zero result flags that bit in error.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     in_valid/in_ready    load handshake for sigma and err_count
//     sigma                sigma_0..sigma_T, M bits each, sigma_0 at LSB
//     err_count            degree of sigma reported by the key solver
//     out_valid/out_ready  per-position output handshake
//     out_err              bit at this position is in error
//     out_first/out_last   position 0 / position L-1 markers
//     out_fail             with out_last: roots found != err_count
//   Optional feature macro: BCH_CHIEN_CHECK_EN enables the root-count checker;
//   without it out_fail is tied low.
// ---------------------------------------------------------------------------
module bch_chien_search_serial
  import bch_chien_search_serial_pkg::*;
#(
  parameter int M = BCH_M,
  parameter int T = BCH_T,
  parameter int L = BCH_L
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [sigma_sz(M,T)-1:0] sigma,
  input  logic [err_sz(T)-1:0]     err_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_err,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     out_fail
);

  localparam int EW = err_sz(T);
  localparam int CW = $clog2(L + 1);
  // Shortening offset: position 0 corresponds to alpha^(2^M - L).
  localparam int SHORT = (1 << M) - L;

  chien_state_t  state_reg;
  logic          out_valid_reg;
  logic [CW-1:0] count_reg;
  logic [M-1:0]  term [0:T];
  logic [M-1:0]  term_sum;
  logic          accept;
  logic          consume;
  logic          at_last;
  logic          step;

  generate
    for (genvar gi = 0; gi <= T; gi++) begin : g_term
      bch_chien_search_serial_term #(
        .M          (M),
        .POWER      (gi),
        .LOAD_POWER (gi * SHORT)
      ) u_term (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (step),
        .coeff (sigma[gi*M +: M]),
        .term  (term[gi])
      );
    end
  endgenerate

  always_comb begin
    term_sum = '0;
    for (int i = 0; i <= T; i++) term_sum = term_sum ^ term[i];
  end

  assign at_last  = (count_reg == CW'(L - 1));
  assign consume  = out_valid_reg && out_ready;
  // A reload on the last-beat consume gives back-to-back codewords.
  assign in_ready = (state_reg == ST_IDLE) || (consume && at_last);
  assign accept   = in_valid && in_ready;
  assign step     = consume && !at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      count_reg     <= '0;
    end else if (accept) begin
      state_reg     <= ST_RUN;
      out_valid_reg <= 1'b1;
      count_reg     <= '0;
    end else if (consume && at_last) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
    end else if (step) begin
      count_reg     <= count_reg + CW'(1);
    end
  end

  // Flags are qualified by out_valid so the idle/reset terms (all zero) never
  // look like a root.
  assign out_valid = out_valid_reg;
  assign out_err   = out_valid_reg && (term_sum == '0);
  assign out_first = out_valid_reg && (count_reg == '0);
  assign out_last  = out_valid_reg && at_last;

`ifdef BCH_CHIEN_CHECK_EN
  logic [EW-1:0] roots_reg;
  logic [EW-1:0] err_latch_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      roots_reg     <= '0;
      err_latch_reg <= '0;
    end else if (accept) begin
      roots_reg     <= '0;
      err_latch_reg <= err_count;
    end else if (consume && out_err && (roots_reg != {EW{1'b1}})) begin
      roots_reg     <= roots_reg + EW'(1);
    end
  end

  // The last beat's own flag is not yet in roots_reg, so add it here.
  assign out_fail = out_last &&
                    (({1'b0, roots_reg} + {{EW{1'b0}}, out_err}) != {1'b0, err_latch_reg});
`else
  logic unused_err_count;
  assign unused_err_count = ^err_count;
  assign out_fail = 1'b0;
`endif

endmodule

// File: tb/tb_bch_chien_search_serial.sv
module tb_bch_chien_search_serial;

  localparam int M  = 4;
  localparam int T  = 2;
  localparam int L  = 15;
  localparam int N  = 15;
  localparam int SW = (T + 1) * M;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sigma;
  logic [EW-1:0] err_count;
  logic          out_valid;
  logic          out_ready;
  logic          out_err;
  logic          out_first;
  logic          out_last;
  logic          out_fail;

  int total = 0;
  int bad   = 0;
  int exp_t [0:N-1];
  int log_t [0:N];
  bit check_en;

  always #5 clk = ~clk;

  bch_chien_search_serial #(.M(M), .T(T), .L(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sigma     (sigma),
    .err_count (err_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
    .out_first (out_first),
    .out_last  (out_last),
    .out_fail  (out_fail)
  );

  task automatic check_val(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // ---- GF(16) reference arithmetic via log/antilog tables -----------------
  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % N];
  endfunction

  function automatic int apow(input int e);
    return exp_t[((e % N) + N) % N];
  endfunction

  // sigma(x) evaluated at x = alpha^(j-L+1) by Horner-free power sum
  function automatic int eval_at(input logic [SW-1:0] s, input int j);
    int x, xp, acc;
    x   = apow(j - L + 1);
    xp  = 1;
    acc = 0;
    for (int i = 0; i <= T; i++) begin
      acc = acc ^ gmul(int'(s[i*M +: M]), xp);
      xp  = gmul(xp, x);
    end
    return acc;
  endfunction

  // Locator polynomial prod(1 + X_k x) with X_k = alpha^(L-1-pos_k)
  function automatic logic [SW-1:0] sigma_from_pos(input int n, input int p0, input int p1);
    int c0, c1, c2, x;
    logic [SW-1:0] s;
    c0 = 1; c1 = 0; c2 = 0;
    if (n >= 1) begin
      x  = apow(L - 1 - p0);
      c1 = c1 ^ gmul(x, c0);
    end
    if (n >= 2) begin
      x  = apow(L - 1 - p1);
      c2 = c2 ^ gmul(x, c1);
      c1 = c1 ^ gmul(x, c0);
    end
    s = {M'(c2), M'(c1), M'(c0)};
    return s;
  endfunction

  function automatic int count_roots(input logic [SW-1:0] s);
    int n;
    n = 0;
    for (int j = 0; j < L; j++) if (eval_at(s, j) == 0) n++;
    return n;
  endfunction

  // ---- drivers -------------------------------------------------------------
  // Called at a negedge; returns at a negedge after the accepting edge.
  task automatic load(input logic [SW-1:0] s, input int ec);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    sigma     = s;
    err_count = EW'(ec);
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check_val("load_timeout", 0, 1);
  endtask

  // Checks beats 0..L-1 (or stops, at a negedge, when beat stop_at is shown).
  // With chain set, the next codeword is offered during the last beat.
  task automatic check_beats(input logic [SW-1:0] s, input int ec, input int rdy_pct,
                             input int stop_at, input bit chain,
                             input logic [SW-1:0] s2, input int ec2);
    int exp_err [L];
    int nroots, b, cyc, exp_fail;
    bit rdy;
    nroots = 0;
    for (int j = 0; j < L; j++) begin
      exp_err[j] = (eval_at(s, j) == 0) ? 1 : 0;
      nroots += exp_err[j];
    end
    exp_fail = (check_en && (nroots != ec)) ? 1 : 0;
    b   = 0;
    cyc = 0;
    while (b < L && cyc < 400) begin
      cyc++;
      check_val($sformatf("valid[%0d]", b), int'(out_valid), 1);
      check_val($sformatf("err[%0d]", b), int'(out_err), exp_err[b]);
      check_val($sformatf("first[%0d]", b), int'(out_first), (b == 0) ? 1 : 0);
      check_val($sformatf("last[%0d]", b), int'(out_last), (b == L - 1) ? 1 : 0);
      check_val($sformatf("fail[%0d]", b), int'(out_fail), (b == L - 1) ? exp_fail : 0);
      if (b == stop_at) return;
      rdy = ($urandom_range(99) < rdy_pct);
      out_ready = rdy;
      if (chain && b == L - 1 && rdy) begin
        in_valid  = 1'b1;
        sigma     = s2;
        err_count = EW'(ec2);
      end
      #1;
      check_val($sformatf("in_ready[%0d]", b), int'(in_ready), (rdy && b == L - 1) ? 1 : 0);
      @(posedge clk);
      if (rdy) b++;
      @(negedge clk);
      in_valid = 1'b0;
    end
    if (b < L) check_val("beat_timeout", b, L);
    else if (!chain) begin
      check_val("idle_valid", int'(out_valid), 0);
      check_val("idle_ready", int'(in_ready), 1);
    end
    $display("codeword done: roots=%0d err_count=%0d ready_pct=%0d chain=%0d", nroots, ec, rdy_pct, chain);
  endtask

  initial begin
    logic [SW-1:0] s, s2;
    int v, n, p0, p1, ec;

`ifdef BCH_CHIEN_CHECK_EN
    check_en = 1'b1;
`else
    check_en = 1'b0;
`endif
    v = 1;
    for (int k = 0; k < N; k++) begin
      exp_t[k] = v;
      log_t[v] = k;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 19;
    end
    log_t[0] = 0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sigma = '0; err_count = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_ready", int'(in_ready), 1);
    check_val("rst_err", int'(out_err), 0);
    check_val("rst_first", int'(out_first), 0);
    check_val("rst_last", int'(out_last), 0);
    check_val("rst_fail", int'(out_fail), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1. no errors
    s = sigma_from_pos(0, 0, 0);
    load(s, 0);
    check_beats(s, 0, 100, L, 1'b0, '0, 0);

    // 2. single error at position 3
    s = sigma_from_pos(1, 3, 0);
    load(s, 1);
    check_beats(s, 1, 100, L, 1'b0, '0, 0);

    // 3. errors at 0 and 14 with out_ready back-pressure
    s = sigma_from_pos(2, 0, 14);
    load(s, 2);
    check_beats(s, 2, 50, L, 1'b0, '0, 0);

    // 4. undecodable: degree-2 sigma with no roots
    s = sigma_from_pos(2, 1, 2);
    for (int k = 0; k < 200; k++) begin
      s = {M'($urandom_range(1, 15)), M'($urandom_range(0, 15)), M'(1)};
      if (count_roots(s) == 0) break;
    end
    load(s, 2);
    check_beats(s, 2, 70, L, 1'b0, '0, 0);

    // 5. back-to-back codewords
    s  = sigma_from_pos(2, 5, 9);
    s2 = sigma_from_pos(1, 2, 0);
    load(s, 2);
    check_beats(s, 2, 100, L, 1'b1, s2, 1);
    check_beats(s2, 1, 100, L, 1'b0, '0, 0);

    // 6. reset at beat 7, then a fresh load
    s = sigma_from_pos(2, 4, 11);
    load(s, 2);
    check_beats(s, 2, 100, 7, 1'b0, '0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_valid", int'(out_valid), 0);
    check_val("midrst_ready", int'(in_ready), 1);
    reset = 1'b0;
    s = sigma_from_pos(1, 14, 0);
    load(s, 1);
    check_beats(s, 1, 100, L, 1'b0, '0, 0);

    // 7. randomized codewords, occasionally with a wrong err_count
    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(0, 2);
      p0 = $urandom_range(0, L - 1);
      p1 = $urandom_range(0, L - 1);
      while (p1 == p0) p1 = $urandom_range(0, L - 1);
      s  = sigma_from_pos(n, p0, p1);
      ec = ($urandom_range(3) == 0) ? (n + 1) % 3 : n;
      load(s, ec);
      check_beats(s, ec, $urandom_range(40, 100), L, 1'b0, '0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
